// File: rtl/bcd_conv_sched.sv
// Shared iterative binary-to-BCD converter (shift-add-3, one bit per clock) with a
// round-robin req/ack front end. Define BCD_SAT_EN to clamp overflowing results to all nines.
module bcd_conv_sched #(
    parameter int BIN_W  = 28,
    parameter int DIGITS = 8,
    parameter int NREQ   = 2
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*BIN_W-1:0]  bin_in,
    output logic [NREQ-1:0]        ack,
    output logic                   busy,
    output logic [4*DIGITS-1:0]    bcd_out,
    output logic                   bcd_valid,
    output logic [1:0]             bcd_id,
    output logic                   overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    // 10^n, saturating once it is beyond any legal operand range
    function automatic logic [63:0] pow10_sat(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int k = 0; k < n; k++) begin
            v = (v > 64'h1_0000_0000) ? v : v * 64'd10;
        end
        return v;
    endfunction

    localparam logic [63:0]    P10         = pow10_sat(DIGITS);
    localparam logic [63:0]    BIN_MAX     = (64'd1 << BIN_W) - 64'd1;
    localparam bit             OV_POSSIBLE = (P10 <= BIN_MAX);
    localparam logic [BIN_W:0] LIMIT       = P10[BIN_W:0];

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        ptr_reg, ptr_next;
    logic [1:0]        id_cur_reg, id_cur_next;
    logic [BW-1:0]     acc_reg, acc_next;
    logic [BIN_W-1:0]  opr_reg, opr_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              ov_flag_reg, ov_flag_next;
    logic [NREQ-1:0]   ack_reg, ack_next;
    logic              busy_reg, busy_next;
    logic [BW-1:0]     bcd_reg, bcd_next;
    logic              valid_reg, valid_next;
    logic [1:0]        id_out_reg, id_out_next;
    logic              ovf_out_reg, ovf_out_next;

    logic [3:0]        req_pad;
    logic [BIN_W-1:0]  bin_arr [4];
    logic [BW-1:0]     acc_adj;
    logic [BW-1:0]     acc_shift;
    logic [BW-1:0]     result;
    logic [1:0]        cand;
    logic [1:0]        gidx;
    logic              found;
    logic [NREQ-1:0]   grant_oh;
    logic              ov_cand;

    // Pad requesters to four slots so the arbiter can index without range issues
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            if (gi < NREQ) begin : g_used
                assign req_pad[gi] = req[gi];
                assign bin_arr[gi] = bin_in[gi*BIN_W +: BIN_W];
            end else begin : g_unused
                assign req_pad[gi] = 1'b0;
                assign bin_arr[gi] = '0;
            end
        end
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                        acc_reg[4*gi +: 4] + 4'd3 : acc_reg[4*gi +: 4];
        end
    endgenerate

    // Carry out of the top digit falls off: result is operand mod 10^DIGITS
    assign acc_shift = (acc_adj << 1) | BW'(opr_reg[BIN_W-1]);

`ifdef BCD_SAT_EN
    assign result = ov_flag_reg ? {DIGITS{4'h9}} : acc_shift;
`else
    assign result = acc_shift;
`endif

    always_comb begin
        found = 1'b0;
        gidx  = 2'd0;
        cand  = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = 2'((int'(ptr_reg) + k) % NREQ);
            if (!found && req_pad[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        grant_oh = NREQ'(1) << gidx;
        ov_cand  = OV_POSSIBLE && ({1'b0, bin_arr[gidx]} >= LIMIT);
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        id_cur_next  = id_cur_reg;
        acc_next     = acc_reg;
        opr_next     = opr_reg;
        cnt_next     = cnt_reg;
        ov_flag_next = ov_flag_reg;
        ack_next     = '0;
        busy_next    = busy_reg;
        bcd_next     = bcd_reg;
        valid_next   = 1'b0;
        id_out_next  = id_out_reg;
        ovf_out_next = ovf_out_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    ack_next     = grant_oh;
                    opr_next     = bin_arr[gidx];
                    acc_next     = '0;
                    cnt_next     = CW'(BIN_W);
                    busy_next    = 1'b1;
                    ov_flag_next = ov_cand;
                    id_cur_next  = gidx;
                    ptr_next     = 2'((int'(gidx) + 1) % NREQ);
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                acc_next = acc_shift;
                opr_next = opr_reg << 1;
                cnt_next = cnt_reg - CW'(1);
                // Result registers load on the final shift so the strobe is visible in DONE
                if (cnt_reg == CW'(1)) begin
                    busy_next    = 1'b0;
                    valid_next   = 1'b1;
                    bcd_next     = result;
                    id_out_next  = id_cur_reg;
                    ovf_out_next = ov_flag_reg;
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= 2'd0;
            id_cur_reg  <= 2'd0;
            acc_reg     <= '0;
            opr_reg     <= '0;
            cnt_reg     <= '0;
            ov_flag_reg <= 1'b0;
            ack_reg     <= '0;
            busy_reg    <= 1'b0;
            bcd_reg     <= '0;
            valid_reg   <= 1'b0;
            id_out_reg  <= 2'd0;
            ovf_out_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            id_cur_reg  <= id_cur_next;
            acc_reg     <= acc_next;
            opr_reg     <= opr_next;
            cnt_reg     <= cnt_next;
            ov_flag_reg <= ov_flag_next;
            ack_reg     <= ack_next;
            busy_reg    <= busy_next;
            bcd_reg     <= bcd_next;
            valid_reg   <= valid_next;
            id_out_reg  <= id_out_next;
            ovf_out_reg <= ovf_out_next;
        end
    end

    assign ack       = ack_reg;
    assign busy      = busy_reg;
    assign bcd_out   = bcd_reg;
    assign bcd_valid = valid_reg;
    assign bcd_id    = id_out_reg;
    assign overflow  = ovf_out_reg;

endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Shares one iterative shift-add-3 binary-to-BCD engine between up to 4 measurement requesters in the frequency meter, e.g. frequency, period and duty results.
- Round-robin arbitration with a req/ack handshake on the request side.
- Runs one bit per clock and delivers 8-digit packed BCD with a requester ID and an overflow flag for the display and UART stages.
- Replaces per-channel combinational converters to save area.

Parameters:
- BIN_W, 28, binary input width per requester. Legal range 4..32.
- DIGITS, 8, number of BCD output digits. Output width is 4*DIGITS.
- NREQ, 2, number of requesters. Legal range 1..4.

Ports:
- Clk  in  1  system clock. All logic is on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester conversion request (level).
- bin_in  in  NREQ*BIN_W  packed operands. Requester i uses bits [i*BIN_W +: BIN_W].
- ack  out  NREQ  one-cycle grant pulse. Operand is captured on that edge.
- busy  out  1  high from the grant edge until the result edge.
- bcd_out  out  4*DIGITS  packed BCD result, most significant digit in the top nibble.
- bcd_valid  out  1  one-cycle result strobe.
- bcd_id  out  2  index of the requester that owns the result.
- overflow  out  1  operand was >= 10^DIGITS. Qualified by bcd_valid.

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE. Round-robin pointer points at requester 0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - At each edge, if any req is high, grant one requester (round-robin, below).
  - On the grant edge: ack[i]=1 for exactly one cycle, operand latched into the shift register, BCD accumulator cleared, bit counter=BIN_W, busy=1, ov_flag latched as (operand >= 10^DIGITS), next state SHIFT.
- SHIFT, one bit per edge:
  - Every BCD digit >= 5 gets +3.
  - Then the {accumulator, operand} register shifts left by 1. The operand MSB enters the accumulator LSB.
  - The counter decrements. When the counter reaches 0 after BIN_W shifts, go to DONE.
  - Carries out of the top digit are discarded, so the result is the operand mod 10^DIGITS.
- DONE, one edge:
  - bcd_out <= accumulator, bcd_id <= granted index, overflow <= ov_flag.
  - bcd_valid=1 for one cycle, busy=0, go to IDLE.
- Latency: ack is high in cycle 1 and bcd_valid in cycle BIN_W+1 (cycle 29 for the defaults). Back-to-back period is BIN_W+2 cycles.
- Round-robin arbitration:
  - The search starts at (last_grant+1) mod NREQ and the first high req wins.
  - After reset, requester 0 has top priority.
  - Requests arriving while busy wait. They are not queued beyond the req level.
- Handshake rules:
  - A requester holds req and bin_in stable until it sees ack, then drops req in the ack cycle.
  - A req still high at a later IDLE sampling edge counts as a new request.
  - Dropping req before ack cancels it with no side effect.
  - bin_in is ignored outside the grant edge.
- Output holding:
  - bcd_out, bcd_id and overflow hold their value until the next DONE.
  - bcd_valid and ack are never high in the same cycle as each other's previous pulse for the same transaction.
- Rst mid-conversion: the conversion is abandoned. No bcd_valid is produced, outputs go to 0 and the pointer goes to 0.
- NREQ=1: arbitration degenerates to a direct grant. bcd_id stays 0.
- Unused ack bits are 0.
- The 10^DIGITS compare is done at full BIN_W+1 width.
  - If 10^DIGITS exceeds the BIN_W range, overflow is constant 0.

Optional Feature:
- Macro: BCD_SAT_EN.
- Defined: when ov_flag is set, DONE loads bcd_out with all nines (every digit 4'h9) instead of the mod-10^DIGITS accumulator. overflow still asserts.
- Undefined: bcd_out is always the truncated accumulator (value mod 10^DIGITS). overflow is reported only.

Test Plan:
1. Single conversion: Rst then req[0]=1 with bin=28'd12345678. Expect:
   - ack[0] in cycle 1 and busy high in cycles 1..28.
   - bcd_valid in cycle 29 with bcd_out=32'h12345678, bcd_id=0, overflow=0.
2. Simultaneous requests after reset: req=2'b11 with bin0=0 and bin1=28'd99999999. Expect:
   - requester 0 granted first, giving bcd_out=32'h00000000 with id 0.
   - then requester 1, giving bcd_out=32'h99999999 with id 1 and overflow=0.
   - the two bcd_valid pulses 30 cycles apart.
3. Fairness: both requesters re-assert req immediately after every ack for 6 conversions. Expect:
   - grants alternate 0,1,0,1,0,1.
   - no ack while busy.
4. Overflow at the maximum operand: bin=28'hFFFFFFF (268435455). Expect:
   - overflow=1.
   - bcd_out=32'h68435455 without BCD_SAT_EN.
   - bcd_out=32'h99999999 with BCD_SAT_EN.
5. Overflow boundary: bin=100000000 gives overflow=1 and bcd_out=32'h00000000 (32'h99999999 with the macro). bin=99999999 gives overflow=0.
6. Reset mid-operation: Rst=1 for one cycle at cycle 10 of a conversion. Expect:
   - no bcd_valid.
   - busy=0 and bcd_out=0.
   - a following req[1] with bin=28'd42 is granted and yields bcd_out=32'h00000042 with id 1.
